// File: rtl/lvds_pattern_pkg.sv
// Shared types and PRBS7 constants for the LVDS pattern generator.
// PRBS logic is only built when LVDS_PATTERN_PRBS_EN is defined.
package lvds_pattern_pkg;

  typedef enum logic [1:0] {
    STATIC = 2'd0,
    TOGGLE = 2'd1,
    WALK   = 2'd2,
    PRBS   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    SYNC = 2'd2
  } state_e;

  localparam int unsigned PRBS_W = 7;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 7'h7F;
  localparam int unsigned PRBS_TAP_A = 6;
  localparam int unsigned PRBS_TAP_B = 5;

  // One PRBS7 shift: x^7 + x^6 + 1, feedback enters at bit 0.
  function automatic logic [PRBS_W-1:0] prbs_step(input logic [PRBS_W-1:0] lfsr);
    return {lfsr[PRBS_W-2:0], lfsr[PRBS_TAP_A] ^ lfsr[PRBS_TAP_B]};
  endfunction

endpackage

// File: rtl/TLVDS_OBUF.sv
// Behavioural stand-in for the vendor true-LVDS output buffer; the vendor
// library cell replaces this file in the implementation flow.
module TLVDS_OBUF (
  input  logic I,
  output logic O,
  output logic OB
);

  assign O  = I;
  assign OB = ~I;

endmodule

// File: rtl/lvds_prescaler.sv
// Tick prescaler: counts 0..div and strobes tick on terminal count while enabled.
module lvds_prescaler #(
  parameter int unsigned DIV_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic             at_tc;

  assign at_tc = (cnt == div);
  assign tick  = en && at_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_tc ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/lvds_pattern_gen.sv
// Multi-channel LVDS pattern generator (static/toggle/walking/PRBS7) with
// runtime divider and per-channel inversion. PRBS7 needs LVDS_PATTERN_PRBS_EN.
module lvds_pattern_gen
  import lvds_pattern_pkg::*;
#(
  parameter int unsigned       CHANNELS    = 4,
  parameter int unsigned       DIV_W       = 26,
  parameter logic [DIV_W-1:0]  DEFAULT_DIV = DIV_W'(26'h0FF_FFFF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_mode,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [CHANNELS-1:0] cfg_inv,
  output logic                tick,
  output logic [CHANNELS-1:0] tlvds_p,
  output logic [CHANNELS-1:0] tlvds_n
);

  state_e              state, state_nxt;
  logic                cfg_ready_nxt;
  logic                hs;
  mode_e               mode_q, cfg_mode_eff;
  logic [DIV_W-1:0]    div_q;
  logic [CHANNELS-1:0] inv_q;
  logic [CHANNELS-1:0] pat, pat_nxt, pat_seed, pat_adv, pat_rot;
  logic [CHANNELS-1:0] data_q;

  assign hs = cfg_valid && cfg_ready;

  // Control FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_ready <= cfg_ready_nxt;
    end
  end

  // Control FSM: next state; cfg_ready is registered so it tracks state==RUN.
  always_comb begin
    state_nxt     = state;
    cfg_ready_nxt = 1'b0;
    case (state)
      INIT:    state_nxt = RUN;
      RUN:     if (hs) state_nxt = SYNC;
      SYNC:    state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
    cfg_ready_nxt = (state_nxt == RUN);
  end

  // Counter is cleared on the way into SYNC so it sits at 0 throughout SYNC.
  lvds_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_nxt != RUN),
    .en    (state == RUN),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
`ifdef LVDS_PATTERN_PRBS_EN
    cfg_mode_eff = mode_e'(cfg_mode);
`else
    cfg_mode_eff = (cfg_mode == 2'd3) ? TOGGLE : mode_e'(cfg_mode);
`endif
  end

  // Rotate-left by one; degenerates to a hold when CHANNELS==1.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_rot
    assign pat_rot[g] = pat[(g + CHANNELS - 1) % CHANNELS];
  end

`ifdef LVDS_PATTERN_PRBS_EN
  logic [PRBS_W-1:0]   lfsr, lfsr_adv;
  logic [CHANNELS-1:0] pat_prbs_seed, pat_prbs_adv;

  assign lfsr_adv = prbs_step(lfsr);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_prbs_map
    assign pat_prbs_seed[g] = PRBS_SEED[g % PRBS_W];
    assign pat_prbs_adv[g]  = lfsr_adv[g % PRBS_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= PRBS_SEED;
    end else if (state != RUN) begin
      lfsr <= PRBS_SEED;
    end else if (tick && !hs && (mode_q == PRBS)) begin
      lfsr <= lfsr_adv;
    end
  end
`endif

  always_comb begin
    pat_seed = '0;
    pat_adv  = '0;
    case (mode_q)
      TOGGLE: pat_adv = ~pat;
      WALK: begin
        pat_seed = CHANNELS'(1);
        pat_adv  = pat_rot;
      end
`ifdef LVDS_PATTERN_PRBS_EN
      PRBS: begin
        pat_seed = pat_prbs_seed;
        pat_adv  = pat_prbs_adv;
      end
`endif
      default: ;
    endcase
  end

  // A handshake in a tick cycle wins: the advance is dropped, SYNC reseeds.
  always_comb begin
    pat_nxt = pat;
    if (state != RUN) begin
      pat_nxt = pat_seed;
    end else if (tick && !hs) begin
      pat_nxt = pat_adv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= TOGGLE;
      div_q  <= DEFAULT_DIV;
      inv_q  <= '0;
      pat    <= '0;
      data_q <= '0;
    end else begin
      if (hs) begin
        mode_q <= cfg_mode_eff;
        div_q  <= cfg_div;
        inv_q  <= cfg_inv;
      end
      pat    <= pat_nxt;
      data_q <= pat ^ inv_q;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_obuf
    TLVDS_OBUF u_obuf (
      .I  (data_q[g]),
      .O  (tlvds_p[g]),
      .OB (tlvds_n[g])
    );
  end

endmodule

// File: tb/tb_lvds_pattern_gen.sv
// Self-checking bench for lvds_pattern_gen: directed scenarios plus randomized
// configurations compared against a cycle-offset reference model.
module tb_lvds_pattern_gen;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 26;
  localparam int DEF_DIV = 32'h00FF_FFFF;

  logic          clk;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_div;
  logic [CH-1:0] cfg_inv;
  logic          tick;
  logic [CH-1:0] tlvds_p;
  logic [CH-1:0] tlvds_n;

  lvds_pattern_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .cfg_inv   (cfg_inv),
    .tick      (tick),
    .tlvds_p   (tlvds_p),
    .tlvds_n   (tlvds_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: active config, the one before it, and cycle offset from handshake.
  int         cur_mode, cur_div, cur_off;
  logic [3:0] cur_inv;
  int         prev_mode, prev_div, prev_oh;
  logic [3:0] prev_inv;

  function automatic int eff_mode(input int m);
`ifdef LVDS_PATTERN_PRBS_EN
    return m;
`else
    return (m == 3) ? 1 : m;
`endif
  endfunction

  // Pattern visible on the pins at offset 'off' (ticks at off>=2 show up 2 cycles later).
  function automatic logic [3:0] model_pat(input int mode, input int div, input int off);
    int k;
    logic [6:0] l;
    logic [3:0] p;
    k = 0;
    if (off - 2 >= 2 + div) k = (off - 4 - div) / (div + 1) + 1;
    case (mode)
      0: p = 4'h0;
      1: p = (k % 2 == 1) ? 4'hF : 4'h0;
      2: begin
        p = 4'b0001;
        p = p << (k % 4);
      end
      default: begin
        l = 7'h7F;
        for (int i = 0; i < k; i++) l = {l[5:0], l[6] ^ l[5]};
        p = l[3:0];
      end
    endcase
    return p;
  endfunction

  // Offsets 1..2 still show the old pattern; inversion switches one cycle earlier.
  function automatic logic [3:0] exp_pins(input int off);
    if (off >= 3) return model_pat(cur_mode, cur_div, off) ^ cur_inv;
    if (off == 2) return model_pat(prev_mode, prev_div, prev_oh + 1) ^ cur_inv;
    return model_pat(prev_mode, prev_div, prev_oh + 1) ^ prev_inv;
  endfunction

  function automatic logic exp_tick(input int off);
    if (off < 2) return 1'b0;
    return ((off - 2) % (cur_div + 1)) == cur_div;
  endfunction

  task automatic step();
    @(negedge clk);
    cur_off++;
  endtask

  task automatic model_after_reset();
    prev_mode = 0; prev_div = 0; prev_inv = 4'h0; prev_oh = 2;
    cur_mode  = 1; cur_div = DEF_DIV; cur_inv = 4'h0; cur_off = 1;
  endtask

  // Present a config at a negedge once ready; returns at offset 1 with valid dropped.
  task automatic do_cfg(input int mode, input int div, input logic [3:0] inv);
    int guard;
    guard = 0;
    while (cfg_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) begin
      n_checks++;
      $display("FAIL cfg_ready_timeout got=%b exp=1", cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_mode  = 2'(mode);
    cfg_div   = DW'(div);
    cfg_inv   = inv;
    prev_mode = cur_mode; prev_div = cur_div; prev_inv = cur_inv; prev_oh = cur_off;
    cur_mode  = eff_mode(mode); cur_div = div; cur_inv = inv; cur_off = 0;
    step();
    cfg_valid = 1'b0;
    cfg_mode  = 2'($urandom);
    cfg_div   = DW'($urandom);
    cfg_inv   = 4'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tlvds_p !== 4'h0 || tlvds_n !== 4'hF)
      $display("FAIL reset_pins got p=%b n=%b exp p=0000 n=1111", tlvds_p, tlvds_n);
    else n_pass++;
    n_checks++;
    if (cfg_ready !== 1'b0 || tick !== 1'b0)
      $display("FAIL reset_ctrl got ready=%b tick=%b exp 0 0", cfg_ready, tick);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b0) $display("FAIL release_ready0 got=%b exp=0", cfg_ready);
    else n_pass++;
    model_after_reset();
    step();
    n_checks++;
    if (cfg_ready !== 1'b1) $display("FAIL release_ready1 got=%b exp=1", cfg_ready);
    else n_pass++;
    // Drive a toggling pattern, then reset while pins read 1111.
    do_cfg(1, 0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (tlvds_p !== exp_pins(cur_off) || tlvds_n !== ~exp_pins(cur_off))
        $display("FAIL prereset_pins off=%0d got p=%b n=%b exp p=%b",
                 cur_off, tlvds_p, tlvds_n, exp_pins(cur_off));
      else n_pass++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (tlvds_p !== 4'h0 || tlvds_n !== 4'hF || cfg_ready !== 1'b0 || tick !== 1'b0)
      $display("FAIL midrun_reset got p=%b n=%b ready=%b tick=%b exp 0000 1111 0 0",
               tlvds_p, tlvds_n, cfg_ready, tick);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cfg_ready !== 1'b0) $display("FAIL rerelease_ready0 got=%b exp=0", cfg_ready);
    else n_pass++;
    model_after_reset();
    step();
    n_checks++;
    if (cfg_ready !== 1'b1) $display("FAIL rerelease_ready1 got=%b exp=1", cfg_ready);
    else n_pass++;
  endtask

  // Directed scenario: configure, then check sync, tick and pins for n cycles.
  task automatic test_mode(input string name, input int mode, input int div,
                           input logic [3:0] inv, input int n);
    do_cfg(mode, div, inv);
    n_checks++;
    if (cfg_ready !== 1'b0 || tick !== 1'b0)
      $display("FAIL %s_sync got ready=%b tick=%b exp 0 0", name, cfg_ready, tick);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      step();
      n_checks++;
      if (tick !== exp_tick(cur_off))
        $display("FAIL %s_tick off=%0d got=%b exp=%b", name, cur_off, tick, exp_tick(cur_off));
      else n_pass++;
      n_checks++;
      if (tlvds_p !== exp_pins(cur_off) || tlvds_n !== ~exp_pins(cur_off))
        $display("FAIL %s_pins off=%0d got p=%b n=%b exp p=%b",
                 name, cur_off, tlvds_p, tlvds_n, exp_pins(cur_off));
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    int guard;
    do_cfg(1, 1, 4'h0);
    guard = 0;
    while (!(cur_off >= 4 && tick === 1'b1) && guard < 20) begin
      step();
      guard++;
    end
    n_checks++;
    if (guard >= 20) $display("FAIL collision_tick_wait got=%b exp=1", tick);
    else n_pass++;
    // Handshake lands in the tick cycle; offset 2 must show the un-advanced pattern.
    do_cfg(2, 4, 4'h0);
    for (int i = 0; i < 14; i++) begin
      step();
      n_checks++;
      if (tlvds_p !== exp_pins(cur_off) || tlvds_n !== ~exp_pins(cur_off))
        $display("FAIL collision_pins off=%0d got p=%b n=%b exp p=%b",
                 cur_off, tlvds_p, tlvds_n, exp_pins(cur_off));
      else n_pass++;
      n_checks++;
      if (tick !== exp_tick(cur_off))
        $display("FAIL collision_tick off=%0d got=%b exp=%b", cur_off, tick, exp_tick(cur_off));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    do_cfg(2, 1, 4'b1000);
    n_checks++;
    if (cfg_ready !== 1'b0) $display("FAIL b2b_ready got=%b exp=0", cfg_ready);
    else n_pass++;
    do_cfg(1, 0, 4'b0011);
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (tlvds_p !== exp_pins(cur_off) || tlvds_n !== ~exp_pins(cur_off))
        $display("FAIL b2b_pins off=%0d got p=%b n=%b exp p=%b",
                 cur_off, tlvds_p, tlvds_n, exp_pins(cur_off));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int len;
    for (int c = 0; c < 25; c++) begin
      do_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 4'($urandom));
      len = int'($urandom_range(0, 20));
      for (int i = 0; i < len; i++) begin
        step();
        n_checks++;
        if (tick !== exp_tick(cur_off))
          $display("FAIL rand_tick cfg=%0d off=%0d got=%b exp=%b", c, cur_off, tick, exp_tick(cur_off));
        else n_pass++;
        n_checks++;
        if (tlvds_p !== exp_pins(cur_off) || tlvds_n !== ~exp_pins(cur_off))
          $display("FAIL rand_pins cfg=%0d off=%0d got p=%b n=%b exp p=%b",
                   c, cur_off, tlvds_p, tlvds_n, exp_pins(cur_off));
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
    cfg_div   = '0;
    cfg_inv   = '0;
    test_reset();
    test_mode("toggle", 1, 3, 4'h0, 20);
    test_mode("walking", 2, 3, 4'h0, 24);
    test_mode("prbs", 3, 0, 4'h0, 12);
    test_mode("static_inv", 0, 2, 4'b0101, 10);
    test_collision();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lvds_pattern_gen.md
# lvds_pattern_gen

Multi-channel differential pattern generator that drives `CHANNELS` TLVDS_OBUF pairs from one prescaled tick. It supersedes the single-channel fixed-divider LVDS blinker. It adds a runtime-loadable divider, four pattern modes (static, toggle, walking-one, PRBS7) and per-channel polarity inversion. The block sits at the top level, directly between the system clock and the board's TLVDS pin pairs. It serves as a bring-up and scope/LED test source.

## Interface
- `CHANNELS`, default 4: number of differential output pairs, range 1..16.
- `DIV_W`, default 26: width of the prescaler divider.
- `DEFAULT_DIV`, default 26'h0FF_FFFF: divider value after reset; tick period is `DEFAULT_DIV+1` cycles.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `cfg_valid`  in  1  configuration request.
- `cfg_ready`  out  1  configuration can be accepted this cycle.
- `cfg_mode`  in  2  mode encoding: 0 static, 1 toggle, 2 walking, 3 PRBS7.
- `cfg_div`  in  DIV_W  new divider value.
- `cfg_inv`  in  CHANNELS  per-channel polarity invert.
- `tick`  out  1  prescaler terminal-count strobe.
- `tlvds_p`  out  CHANNELS  differential positive legs.
- `tlvds_n`  out  CHANNELS  differential negative legs.

## Operation
- **States:**
  - INIT: entered on reset.
  - RUN.
  - SYNC.
- **Transitions:**
  - INIT→RUN unconditionally after one cycle.
  - RUN→SYNC on a handshake, i.e. `cfg_valid && cfg_ready`.
  - SYNC→RUN unconditionally.
- **`cfg_ready`:** equals `state==RUN`.
- **On handshake:**
  - `mode_q`, `div_q` and `inv_q` capture the `cfg_*` inputs.
  - `cfg_*` are ignored at all other times.
- **Prescaler:**
  - `cnt` counts 0..`div_q`, then wraps to 0.
  - `tick = (state==RUN) && (cnt==div_q)`; this output is combinational from registers.
  - `div_q=0` gives a tick every RUN cycle.
  - `cnt` is held at 0 in INIT and SYNC.
- **Pattern register `pat`:** width CHANNELS; the seed is applied in SYNC and INIT.

  | mode | seed | on tick |
  |---|---|---|
  | static | all 0 | hold all 0 |
  | toggle | all 0 | `pat <= ~pat` |
  | walking | `pat=1` (ch0) | rotate left by 1; bit CHANNELS-1 wraps to bit 0 |
  | PRBS7 | `lfsr=7'h7F` | `lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}`; `pat[i]=lfsr[i%7]` |

  With CHANNELS=1, walking holds 1.
- **Output:**
  - `data_q <= pat ^ inv_q` every cycle.
  - Each `data_q[i]` drives the `I` input of one TLVDS_OBUF: `O`→`tlvds_p[i]`, `OB`→`tlvds_n[i]`.
- **Handshake in a tick cycle:** the configuration wins. The tick's pattern advance is discarded and `pat` is reseeded in SYNC.
- **Reset asserted mid-operation:** these registers clear immediately (async): state→INIT, `cnt=0`, `pat=0`, `lfsr=7'h7F`, `data_q=0`, `mode_q=toggle`, `div_q=DEFAULT_DIV`, `inv_q=0`.

## Timing
- **Reset values:**
  - `cfg_ready=0`.
  - `tick=0`.
  - `tlvds_p` all 0.
  - `tlvds_n` all 1.
- **Ready after reset:** `cfg_ready` rises 1 cycle after `rst_n` deasserts.
- **Pattern latency:** the tick is high in cycle T; `pat` updates at the end of T; the pins change at the end of T+1.
- **Configuration latency:**
  - Handshake in cycle H.
  - SYNC in H+1, with `cfg_ready=0`.
  - RUN with `cnt=0` in H+2.
  - The first tick under the new divider is in H+2+`div_q`.
  - Pins show seed^inv from H+3.
- **Throughput:** at most one configuration accepted every 2 cycles.

## Configuration
- **`LVDS_PATTERN_PRBS_EN` defined:** mode 3 is PRBS7 as specified above, and the LFSR is instantiated.
- **`LVDS_PATTERN_PRBS_EN` undefined:**
  - No LFSR logic is built.
  - `cfg_mode=3` is captured as toggle, and behaves exactly like mode 1.

## Structure
- **Package `lvds_pattern_pkg`:**
  - `mode_e` (STATIC, TOGGLE, WALK, PRBS).
  - `state_e` (INIT, RUN, SYNC).
  - `PRBS_SEED=7'h7F`.
  - PRBS tap positions 6 and 5.
- **Sub-module `lvds_prescaler`:**
  - Parameter `DIV_W`.
  - Inputs: `clk`, `rst_n`, `clr`, `en`, `div`.
  - Output: `tick`.
  - Holds the counter and terminal-count compare.
- **Top level:** the TLVDS_OBUF array is a generate loop in the top module.

## Test plan
- **Reset:** assert `rst_n=0` mid-run → `tlvds_p=4'b0000`, `tlvds_n=4'b1111`, `cfg_ready=0` in the same cycle. After release, `cfg_ready=1` one cycle later.
- **Toggle:** configure mode 1, div 3, inv 0 → `tick` every 4 cycles. `tlvds_p` alternates 0000/1111, each change 2 edges after its tick, first 1111 at H+7.
- **Walking:** configure mode 2, div 3 → `tlvds_p` shows 0001 (H+3), then 0010, 0100, 1000, 0001 at 4-cycle spacing.
- **PRBS:** configure mode 3, div 0 → `tlvds_p` shows 1111 then 1110, 1100 on successive cycles. With the macro undefined, the same configuration yields 0000, 1111, 0000.
- **Inversion and collision:**
  - Configure mode 0, inv 0101 → `tlvds_p=0101`, `tlvds_n=1010` steady.
  - Handshake in a tick cycle → no pattern advance; the seed appears at H+3.
